// File: rtl/cby_pkg.sv
// Shared types and elaboration helpers for the Y-channel connection block.
// CBY_PARITY_EN adds an even-parity bit to the config chain.
package cby_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } cfg_state_e;

`ifdef CBY_PARITY_EN
    localparam int CBY_PAR_BITS = 1;
`else
    localparam int CBY_PAR_BITS = 0;
`endif

    function automatic int cby_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cby_chain_len(input int num_ipin, input int sel_w, input int par_bits);
        return num_ipin * sel_w + par_bits;
    endfunction

endpackage

// File: rtl/cby_ipin_mux.sv
// One grid-input mux: picks one of MUX_SIZE track bits; out-of-range selects drive 0.
module cby_ipin_mux
    import cby_pkg::*;
#(
    parameter int MUX_SIZE = 10,
    parameter int SEL_W    = 4
) (
    input  logic [MUX_SIZE-1:0] mux_in,
    input  logic [SEL_W-1:0]    sel,
    output logic                mux_out
);

    always_comb begin
        mux_out = 1'b0;
        for (int m = 0; m < MUX_SIZE; m++) begin
            if (sel == SEL_W'(m)) begin
                mux_out = mux_in[m];
            end
        end
    end

endmodule

// File: rtl/cby_param_shadow_cfg.sv
// Y-channel connection block with shadow-loaded mux selects and explicit commit.
// Define CBY_PARITY_EN to append a parity bit to the chain and reject bad frames.
module cby_param_shadow_cfg
    import cby_pkg::*;
#(
    parameter int W          = 20,
    parameter int NUM_IPIN   = 4,
    parameter int MUX_SIZE   = 10,
    parameter int TRACK_STEP = 2
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic [W-1:0]        chany_bottom_in,
    input  logic [W-1:0]        chany_top_in,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    output logic [W-1:0]        chany_bottom_out,
    output logic [W-1:0]        chany_top_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int SEL_W     = cby_clog2(MUX_SIZE);
    localparam int SEL_BITS  = NUM_IPIN * SEL_W;
    localparam int CHAIN_LEN = cby_chain_len(NUM_IPIN, SEL_W, CBY_PAR_BITS);
    localparam int CNT_W     = cby_clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [SEL_BITS-1:0]  active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tail_q, tail_d;
    cfg_state_e           state_q, state_d;
    logic                 shift_en;
    logic                 commit_req;
    logic                 parity_bad;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

    assign shift_en   = ccff_en & ~cfg_commit;
    assign commit_req = cfg_commit & (state_q == FULL);
    assign ccff_tail  = tail_q;
    assign cfg_done   = (state_q == FULL);

`ifdef CBY_PARITY_EN
    logic err_q, err_d;

    // A valid frame has even parity over every chain bit, parity bit included.
    assign parity_bad = ^shadow_q;
    assign cfg_err    = err_q;

    always_comb begin
        err_d = err_q;
        if (commit_req) begin
            err_d = parity_bad;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign parity_bad = 1'b0;
    assign cfg_err    = 1'b0;
`endif

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        // Commit takes priority; a shift in the same cycle is dropped.
        if (commit_req) begin
            cnt_d = '0;
            if (!parity_bad) begin
                active_d = shadow_q[SEL_BITS-1:0];
            end
        end else if (shift_en) begin
            shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
            tail_d   = shadow_q[CHAIN_LEN-1];
            if (cnt_q != CNT_W'(CHAIN_LEN)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = LOADING;
        if (cnt_d == '0) begin
            state_d = EMPTY;
        end else if (cnt_d == CNT_W'(CHAIN_LEN)) begin
            state_d = FULL;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            tail_q   <= 1'b0;
            state_q  <= EMPTY;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            state_q  <= state_d;
        end
    end

    // Mux input m of ipin i taps track (i + (m/2)*TRACK_STEP) mod W; even m from below, odd from above.
    genvar gi, gm;
    generate
        for (gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
            logic [MUX_SIZE-1:0] mux_in;
            for (gm = 0; gm < MUX_SIZE; gm++) begin : g_in
                localparam int TRK = (gi + (gm / 2) * TRACK_STEP) % W;
                if ((gm % 2) == 0) begin : g_even
                    assign mux_in[gm] = chany_bottom_in[TRK];
                end else begin : g_odd
                    assign mux_in[gm] = chany_top_in[TRK];
                end
            end
            cby_ipin_mux #(
                .MUX_SIZE (MUX_SIZE),
                .SEL_W    (SEL_W)
            ) u_mux (
                .mux_in  (mux_in),
                .sel     (active_q[gi*SEL_W +: SEL_W]),
                .mux_out (ipin_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cby_param_shadow_cfg.sv
// Scoreboard bench for cby_param_shadow_cfg; stimulus queues expectations, a negedge monitor checks them.
module tb_cby_param_shadow_cfg;

`ifdef CBY_PARITY_EN
    localparam int CL = 17;
`else
    localparam int CL = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] bot, top;
    logic        head, en, commit;
    logic [19:0] bot_out, top_out;
    logic [3:0]  ipin;
    logic        tail, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] ipin;
        logic       done;
        logic       err;
        logic       chk_tail;
        logic       tail;
        logic [19:0] top_o;
        logic [19:0] bot_o;
    } exp_t;

    exp_t sb[$];

    cby_param_shadow_cfg dut (
        .prog_clk         (clk),
        .pReset           (rst_n),
        .chany_bottom_in  (bot),
        .chany_top_in     (top),
        .ccff_head        (head),
        .ccff_en          (en),
        .cfg_commit       (commit),
        .chany_bottom_out (bot_out),
        .chany_top_out    (top_out),
        .ipin_out         (ipin),
        .ccff_tail        (tail),
        .cfg_done         (done),
        .cfg_err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so every queued expectation is checked at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.tag, "ipin", {16'h0, ipin}, {16'h0, e.ipin});
                cmp(e.tag, "done", {19'h0, done}, {19'h0, e.done});
                cmp(e.tag, "err", {19'h0, err}, {19'h0, e.err});
                cmp(e.tag, "top_out", top_out, e.top_o);
                cmp(e.tag, "bot_out", bot_out, e.bot_o);
                if (e.chk_tail) begin
                    cmp(e.tag, "tail", {19'h0, tail}, {19'h0, e.tail});
                end
                $display("check %s ipin=%b done=%b err=%b tail=%b", e.tag, ipin, done, err, tail);
            end
        end
    end

    // Queue one expectation for the current (idle or about-to-commit) cycle, then advance a clock.
    task automatic expect_out(input string tag, input logic [3:0] ip, input logic dn, input logic er,
                              input logic ct, input logic tl);
        exp_t e;
        e.tag = tag; e.ipin = ip; e.done = dn; e.err = er;
        e.chk_tail = ct; e.tail = tl;
        e.top_o = bot; e.bot_o = top;
        sb.push_back(e);
        tick();
    endtask

    task automatic shift_bits(input logic [16:0] f, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) begin
            head = f[k];
            en   = 1'b1;
            tick();
        end
        en   = 1'b0;
        head = 1'b0;
    endtask

    function automatic logic [16:0] mk_frame(input logic [3:0] s0, input logic [3:0] s1,
                                             input logic [3:0] s2, input logic [3:0] s3);
        logic [16:0] f;
        f[15:0] = {s3, s2, s1, s0};
        f[16]   = ^{s3, s2, s1, s0};
        return f;
    endfunction

    initial begin
        logic [16:0] f2, f3, f4, f5, f6, f6_bad;
        logic        exp_err;
        f2 = mk_frame(4'd3, 4'd0, 4'd0, 4'd0);
        f3 = mk_frame(4'd0, 4'd1, 4'd0, 4'd0);
        f4 = mk_frame(4'd2, 4'd12, 4'd1, 4'd4);
        f5 = mk_frame(4'd2, 4'd0, 4'd0, 4'd8);
        f6 = mk_frame(4'd1, 4'd0, 4'd0, 4'd0);
        f6_bad = f6;
        f6_bad[16] = ~f6[16];
        exp_err = 1'b0;

        rst_n = 1'b0; bot = 20'hA5A5A; top = 20'h0; head = 1'b0; en = 1'b0; commit = 1'b0;
        tick(); tick();
        expect_out("rst_hold", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        expect_out("rst_rel", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);

        // Load ipin0 sel=3 (top_in[2]); routing must change only after the commit edge.
        shift_bits(f2, CL-1, 1);
        expect_out("t2_loading", 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_bits(f2, 0, 0);
        expect_out("t2_full", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
        top = 20'h00004; commit = 1'b1;
        expect_out("t2_pre_commit", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
        commit = 1'b0;
        expect_out("t2_post_commit", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);

        // Partial frame: commit ignored, counter kept.
        shift_bits(f3, CL-1, 1);
        commit = 1'b1;
        expect_out("t3_pre_commit", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        commit = 1'b0;
        expect_out("t3_ignored", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_bits(f3, 0, 0);
        expect_out("t3_count_kept", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);

        // ipin0=2 (bot[2]), ipin1=12 (out of range), ipin2=1 (top[2]), ipin3=4 (bot[7]).
        shift_bits(f4, CL-1, 0);
        commit = 1'b1;
        expect_out("t4_pre_commit", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        commit = 1'b0;
        bot = 20'hFFFFF; top = 20'hFFFFF;
        expect_out("t4_all_ones", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        bot = 20'h00000; top = 20'h00000;
        expect_out("t4_all_zero", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bot = 20'h00000; top = 20'hFFFFF;
        expect_out("t4_top_only", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        bot = 20'hFFFFF; top = 20'h00000;
        expect_out("t4_bot_only", 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Commit and shift together in FULL: commit applies, shift dropped.
        bot = 20'h00804; top = 20'h00000;
        shift_bits(f5, CL-1, 0);
        en = 1'b1; head = 1'b1; commit = 1'b1;
        expect_out("t5_pre_commit", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        en = 1'b0; head = 1'b0; commit = 1'b0;
        expect_out("t5_post_commit", 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_bits(17'h0, 0, 0);
        expect_out("t5_tail_msb", 4'b1101, 1'b0, 1'b0, 1'b1, f5[CL-1]);
        shift_bits(17'h0, 0, 0);
        expect_out("t5_tail_next", 4'b1101, 1'b0, 1'b0, 1'b1, f5[CL-2]);
        shift_bits(17'h0, CL-4, 0);
        expect_out("t5_cnt_cl_minus1", 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        shift_bits(17'h0, 0, 0);
        expect_out("t5_cnt_full", 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);

        bot = 20'h00000; top = 20'hFFFFF;
`ifdef CBY_PARITY_EN
        shift_bits(f6_bad, CL-1, 0);
        commit = 1'b1;
        expect_out("t6_bad_pre", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        commit = 1'b0;
        exp_err = 1'b1;
        expect_out("t6_bad_post", 4'b0000, 1'b0, exp_err, 1'b0, 1'b0);
`endif
        shift_bits(f6, CL-1, 0);
        commit = 1'b1;
        expect_out("t6_good_pre", 4'b0000, 1'b1, exp_err, 1'b0, 1'b0);
        commit = 1'b0;
        expect_out("t6_good_post", 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

        tick(); tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
